// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter_if
// Brief    : Fetch, data, control and memory-side signals of the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if;
    logic        i_req;
    logic [15:0] i_addr;
    logic        i_flush;
    logic        i_ready;
    logic [15:0] i_rdata;

    logic        d_req;
    logic        d_we;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic        d_ready;
    logic [15:0] d_rdata;

    logic        halt;
    logic        mem_read;
    logic        mem_write;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;

    // Arbiter side
    modport slave (
        input  i_req, i_addr, i_flush, d_req, d_we, d_addr, d_wdata,
        input  halt, mem_rdata, mem_ack,
        output i_ready, i_rdata, d_ready, d_rdata,
        output mem_read, mem_write, mem_addr, mem_wdata
    );

    // Requester / memory-model side
    modport master (
        output i_req, i_addr, i_flush, d_req, d_we, d_addr, d_wdata,
        output halt, mem_rdata, mem_ack,
        input  i_ready, i_rdata, d_ready, d_rdata,
        input  mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Single-port memory arbiter between instruction fetch and data
//            access, with data priority, fetch anti-starvation and flush.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter (
    input  wire logic           clk,
    input  wire logic           reset_n,
    mem_port_arbiter_if.slave   bus
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_GNT_I = 2'd1;
    localparam logic [1:0] c_GNT_D = 2'd2;
    localparam logic [1:0] c_RESP  = 2'd3;

    logic [1:0]  r_state, w_state_nxt;
    logic [1:0]  r_starve_cnt, w_starve_cnt;
    logic        r_i_flushed, w_i_flushed;
    logic        r_mem_read, w_mem_read;
    logic        r_mem_write, w_mem_write;
    logic [15:0] r_mem_addr, w_mem_addr;
    logic [15:0] r_mem_wdata, w_mem_wdata;
    logic        r_i_ready, w_i_ready;
    logic        r_d_ready, w_d_ready;
    logic [15:0] r_i_rdata, w_i_rdata;
    logic [15:0] r_d_rdata, w_d_rdata;

    logic w_i_elig;
    logic w_gnt_i;
    logic w_gnt_d;

    // A flushing fetch is not a candidate for arbitration this cycle.
    assign w_i_elig = bus.i_req & ~bus.i_flush;
    assign w_gnt_i  = (r_state == c_IDLE) & ~bus.halt & w_i_elig &
                      (~bus.d_req | (r_starve_cnt == 2'd2));
    assign w_gnt_d  = (r_state == c_IDLE) & ~bus.halt & bus.d_req & ~w_gnt_i;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_gnt_i)      w_state_nxt = c_GNT_I;
                else if (w_gnt_d) w_state_nxt = c_GNT_D;
            end
            c_GNT_I: if (bus.mem_ack) w_state_nxt = c_RESP;
            c_GNT_D: if (bus.mem_ack) w_state_nxt = c_RESP;
            c_RESP:  w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // Next values of the registered outputs; ready pulses default low.
    always_comb begin
        w_starve_cnt = r_starve_cnt;
        w_i_flushed  = r_i_flushed;
        w_mem_read   = r_mem_read;
        w_mem_write  = r_mem_write;
        w_mem_addr   = r_mem_addr;
        w_mem_wdata  = r_mem_wdata;
        w_i_ready    = 1'b0;
        w_d_ready    = 1'b0;
        w_i_rdata    = r_i_rdata;
        w_d_rdata    = r_d_rdata;
        case (r_state)
            c_IDLE: begin
                if (w_gnt_i) begin
                    w_mem_read   = 1'b1;
                    w_mem_write  = 1'b0;
                    w_mem_addr   = bus.i_addr;
                    w_starve_cnt = 2'd0;
                    w_i_flushed  = 1'b0;
                end else if (w_gnt_d) begin
                    w_mem_read   = ~bus.d_we;
                    w_mem_write  = bus.d_we;
                    w_mem_addr   = bus.d_addr;
                    w_mem_wdata  = bus.d_wdata;
                    if (w_i_elig && r_starve_cnt != 2'd2) begin
                        w_starve_cnt = r_starve_cnt + 2'd1;
                    end
                end
            end
            c_GNT_I: begin
                if (bus.i_flush) w_i_flushed = 1'b1;
                if (bus.mem_ack) begin
                    w_mem_read  = 1'b0;
                    w_mem_write = 1'b0;
                    // A flush anywhere in the grant window suppresses delivery.
                    if (!(r_i_flushed || bus.i_flush)) begin
                        w_i_ready = 1'b1;
                        w_i_rdata = bus.mem_rdata;
                    end
                end
            end
            c_GNT_D: begin
                if (bus.mem_ack) begin
                    w_mem_read  = 1'b0;
                    w_mem_write = 1'b0;
                    w_d_ready   = 1'b1;
                    if (!r_mem_write) w_d_rdata = bus.mem_rdata;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_starve_cnt <= 2'd0;
            r_i_flushed  <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_addr   <= 16'h0000;
            r_mem_wdata  <= 16'h0000;
            r_i_ready    <= 1'b0;
            r_d_ready    <= 1'b0;
            r_i_rdata    <= 16'h0000;
            r_d_rdata    <= 16'h0000;
        end else begin
            r_starve_cnt <= w_starve_cnt;
            r_i_flushed  <= w_i_flushed;
            r_mem_read   <= w_mem_read;
            r_mem_write  <= w_mem_write;
            r_mem_addr   <= w_mem_addr;
            r_mem_wdata  <= w_mem_wdata;
            r_i_ready    <= w_i_ready;
            r_d_ready    <= w_d_ready;
            r_i_rdata    <= w_i_rdata;
            r_d_rdata    <= w_d_rdata;
        end
    end

    assign bus.mem_read  = r_mem_read;
    assign bus.mem_write = r_mem_write;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.i_ready   = r_i_ready;
    assign bus.d_ready   = r_d_ready;
    assign bus.i_rdata   = r_i_rdata;
    assign bus.d_rdata   = r_d_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Brief    : Directed self-checking bench for mem_port_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    logic clk;
    logic reset_n;
    int   checks;
    int   bad;

    mem_port_arbiter_if bus ();

    mem_port_arbiter dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Outputs are observed 1 time unit after the rising edge; inputs change there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        bus.i_req = 1'b0; bus.i_addr = 16'h0; bus.i_flush = 1'b0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = 16'h0; bus.d_wdata = 16'h0;
        bus.halt = 1'b0; bus.mem_rdata = 16'h0; bus.mem_ack = 1'b0;
        tick(); tick();
        checks++; if (bus.mem_read  !== 1'b0)     begin bad++; $display("FAIL rst_mem_read: got %b want 0", bus.mem_read); end
        checks++; if (bus.mem_write !== 1'b0)     begin bad++; $display("FAIL rst_mem_write: got %b want 0", bus.mem_write); end
        checks++; if (bus.i_ready   !== 1'b0)     begin bad++; $display("FAIL rst_i_ready: got %b want 0", bus.i_ready); end
        checks++; if (bus.d_ready   !== 1'b0)     begin bad++; $display("FAIL rst_d_ready: got %b want 0", bus.d_ready); end
        checks++; if (bus.mem_addr  !== 16'h0000) begin bad++; $display("FAIL rst_mem_addr: got %h want 0000", bus.mem_addr); end
        checks++; if (bus.mem_wdata !== 16'h0000) begin bad++; $display("FAIL rst_mem_wdata: got %h want 0000", bus.mem_wdata); end
        checks++; if (bus.i_rdata   !== 16'h0000) begin bad++; $display("FAIL rst_i_rdata: got %h want 0000", bus.i_rdata); end
        checks++; if (bus.d_rdata   !== 16'h0000) begin bad++; $display("FAIL rst_d_rdata: got %h want 0000", bus.d_rdata); end
        reset_n = 1'b1;
        tick();
        checks++; if (bus.mem_read !== 1'b0) begin bad++; $display("FAIL rst_idle_read: got %b want 0", bus.mem_read); end
    endtask

    task automatic test_fetch();
        int n;
        n = 0;
        bus.i_req = 1'b1; bus.i_addr = 16'h0010; bus.mem_rdata = 16'hA5A5;
        tick();
        checks++; if (bus.mem_addr  !== 16'h0010) begin bad++; $display("FAIL fetch_addr: got %h want 0010", bus.mem_addr); end
        checks++; if (bus.mem_write !== 1'b0)     begin bad++; $display("FAIL fetch_write: got %b want 0", bus.mem_write); end
        checks++; if (bus.i_ready   !== 1'b0)     begin bad++; $display("FAIL fetch_early_ready: got %b want 0", bus.i_ready); end
        if (bus.mem_read) n++;
        tick(); if (bus.mem_read) n++;
        tick(); if (bus.mem_read) n++;
        bus.mem_ack = 1'b1;
        tick();
        checks++; if (n !== 3)                    begin bad++; $display("FAIL fetch_read_cycles: got %0d want 3", n); end
        checks++; if (bus.mem_read !== 1'b0)      begin bad++; $display("FAIL fetch_read_drop: got %b want 0", bus.mem_read); end
        checks++; if (bus.i_ready  !== 1'b1)      begin bad++; $display("FAIL fetch_ready: got %b want 1", bus.i_ready); end
        checks++; if (bus.i_rdata  !== 16'hA5A5)  begin bad++; $display("FAIL fetch_rdata: got %h want a5a5", bus.i_rdata); end
        bus.i_req = 1'b0; bus.mem_ack = 1'b0;
        tick();
        checks++; if (bus.i_ready !== 1'b0) begin bad++; $display("FAIL fetch_ready_one_cycle: got %b want 0", bus.i_ready); end
    endtask

    task automatic test_collision();
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 16'h0040; bus.d_wdata = 16'h1234;
        bus.i_req = 1'b1; bus.i_addr = 16'h0020; bus.mem_ack = 1'b1; bus.mem_rdata = 16'hBEEF;
        tick();
        checks++; if (bus.mem_write !== 1'b1)     begin bad++; $display("FAIL coll_write: got %b want 1", bus.mem_write); end
        checks++; if (bus.mem_read  !== 1'b0)     begin bad++; $display("FAIL coll_read: got %b want 0", bus.mem_read); end
        checks++; if (bus.mem_wdata !== 16'h1234) begin bad++; $display("FAIL coll_wdata: got %h want 1234", bus.mem_wdata); end
        checks++; if (bus.mem_addr  !== 16'h0040) begin bad++; $display("FAIL coll_addr: got %h want 0040", bus.mem_addr); end
        tick();
        checks++; if (bus.d_ready   !== 1'b1)     begin bad++; $display("FAIL coll_d_ready: got %b want 1", bus.d_ready); end
        checks++; if (bus.i_ready   !== 1'b0)     begin bad++; $display("FAIL coll_i_stall: got %b want 0", bus.i_ready); end
        checks++; if (bus.mem_write !== 1'b0)     begin bad++; $display("FAIL coll_write_drop: got %b want 0", bus.mem_write); end
        checks++; if (bus.d_rdata   !== 16'h0000) begin bad++; $display("FAIL coll_store_rdata: got %h want 0000", bus.d_rdata); end
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.mem_rdata = 16'h5555;
        tick();
        checks++; if (bus.mem_read  !== 1'b0)     begin bad++; $display("FAIL coll_resp_no_grant: got %b want 0", bus.mem_read); end
        tick();
        checks++; if (bus.mem_read  !== 1'b1)     begin bad++; $display("FAIL coll_fetch_grant: got %b want 1", bus.mem_read); end
        checks++; if (bus.mem_addr  !== 16'h0020) begin bad++; $display("FAIL coll_fetch_addr: got %h want 0020", bus.mem_addr); end
        tick();
        checks++; if (bus.i_ready   !== 1'b1)     begin bad++; $display("FAIL coll_i_ready: got %b want 1", bus.i_ready); end
        checks++; if (bus.i_rdata   !== 16'h5555) begin bad++; $display("FAIL coll_i_rdata: got %h want 5555", bus.i_rdata); end
        bus.i_req = 1'b0; bus.mem_ack = 1'b0;
        tick();
    endtask

    task automatic test_starvation();
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 16'h0080;
        bus.i_req = 1'b1; bus.i_addr = 16'h0030; bus.mem_ack = 1'b1; bus.mem_rdata = 16'h1111;
        tick();
        checks++; if (bus.mem_addr !== 16'h0080) begin bad++; $display("FAIL starve_gnt1: got %h want 0080", bus.mem_addr); end
        checks++; if (bus.mem_read !== 1'b1)     begin bad++; $display("FAIL starve_load_read: got %b want 1", bus.mem_read); end
        tick();
        checks++; if (bus.d_ready  !== 1'b1)     begin bad++; $display("FAIL starve_d_ready: got %b want 1", bus.d_ready); end
        checks++; if (bus.d_rdata  !== 16'h1111) begin bad++; $display("FAIL starve_d_rdata: got %h want 1111", bus.d_rdata); end
        tick(); tick();
        checks++; if (bus.mem_addr !== 16'h0080) begin bad++; $display("FAIL starve_gnt2: got %h want 0080", bus.mem_addr); end
        tick(); tick(); tick();
        checks++; if (bus.mem_addr !== 16'h0030) begin bad++; $display("FAIL starve_gnt3_fetch: got %h want 0030", bus.mem_addr); end
        tick();
        checks++; if (bus.i_ready  !== 1'b1)     begin bad++; $display("FAIL starve_i_ready: got %b want 1", bus.i_ready); end
        tick(); tick();
        checks++; if (bus.mem_addr !== 16'h0080) begin bad++; $display("FAIL starve_cnt_cleared: got %h want 0080", bus.mem_addr); end
        bus.i_req = 1'b0;
        tick();
        bus.d_req = 1'b0; bus.mem_ack = 1'b0;
        tick();
    endtask

    task automatic test_flush();
        bus.i_req = 1'b1; bus.i_addr = 16'h0050; bus.mem_rdata = 16'h7777;
        tick();
        checks++; if (bus.mem_read !== 1'b1)     begin bad++; $display("FAIL flush_grant: got %b want 1", bus.mem_read); end
        bus.i_flush = 1'b1;
        tick();
        checks++; if (bus.mem_read !== 1'b1)     begin bad++; $display("FAIL flush_read_held: got %b want 1", bus.mem_read); end
        bus.i_flush = 1'b0; bus.mem_ack = 1'b1; bus.i_req = 1'b0;
        tick();
        checks++; if (bus.mem_read !== 1'b0)     begin bad++; $display("FAIL flush_completes: got %b want 0", bus.mem_read); end
        checks++; if (bus.i_ready  !== 1'b0)     begin bad++; $display("FAIL flush_no_ready: got %b want 0", bus.i_ready); end
        checks++; if (bus.i_rdata  !== 16'h1111) begin bad++; $display("FAIL flush_rdata_kept: got %h want 1111", bus.i_rdata); end
        bus.mem_ack = 1'b0;
        tick();
        checks++; if (bus.i_ready  !== 1'b0)     begin bad++; $display("FAIL flush_no_late_ready: got %b want 0", bus.i_ready); end
        bus.i_req = 1'b1; bus.i_addr = 16'h0060; bus.mem_ack = 1'b1; bus.mem_rdata = 16'h2222;
        tick();
        checks++; if (bus.mem_addr !== 16'h0060) begin bad++; $display("FAIL flush_idle_regrant: got %h want 0060", bus.mem_addr); end
        tick();
        checks++; if (bus.i_rdata  !== 16'h2222) begin bad++; $display("FAIL flush_next_rdata: got %h want 2222", bus.i_rdata); end
        bus.i_req = 1'b0; bus.mem_ack = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 16'h0090; bus.d_wdata = 16'hCAFE;
        tick();
        checks++; if (bus.mem_write !== 1'b1)     begin bad++; $display("FAIL rmid_grant: got %b want 1", bus.mem_write); end
        reset_n = 1'b0; bus.d_req = 1'b0; bus.d_we = 1'b0;
        #1;
        checks++; if (bus.mem_write !== 1'b0)     begin bad++; $display("FAIL rmid_async_write: got %b want 0", bus.mem_write); end
        checks++; if (bus.mem_wdata !== 16'h0000) begin bad++; $display("FAIL rmid_async_wdata: got %h want 0000", bus.mem_wdata); end
        checks++; if (bus.mem_addr  !== 16'h0000) begin bad++; $display("FAIL rmid_async_addr: got %h want 0000", bus.mem_addr); end
        checks++; if (bus.d_rdata   !== 16'h0000) begin bad++; $display("FAIL rmid_async_d_rdata: got %h want 0000", bus.d_rdata); end
        checks++; if (bus.i_rdata   !== 16'h0000) begin bad++; $display("FAIL rmid_async_i_rdata: got %h want 0000", bus.i_rdata); end
        tick();
        reset_n = 1'b1; bus.mem_ack = 1'b1;
        bus.i_req = 1'b1; bus.i_addr = 16'h00A0; bus.mem_rdata = 16'h3333;
        tick();
        checks++; if (bus.d_ready   !== 1'b0)     begin bad++; $display("FAIL rmid_no_d_ready: got %b want 0", bus.d_ready); end
        checks++; if (bus.mem_read  !== 1'b1)     begin bad++; $display("FAIL rmid_first_grant: got %b want 1", bus.mem_read); end
        checks++; if (bus.mem_addr  !== 16'h00A0) begin bad++; $display("FAIL rmid_first_addr: got %h want 00a0", bus.mem_addr); end
        tick();
        checks++; if (bus.d_ready   !== 1'b0)     begin bad++; $display("FAIL rmid_no_d_ready2: got %b want 0", bus.d_ready); end
        checks++; if (bus.i_rdata   !== 16'h3333) begin bad++; $display("FAIL rmid_fetch_rdata: got %h want 3333", bus.i_rdata); end
        bus.i_req = 1'b0; bus.mem_ack = 1'b0;
        tick();
    endtask

    task automatic test_halt();
        bus.halt = 1'b1; bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 16'h00B0;
        bus.i_req = 1'b1; bus.i_addr = 16'h00C0; bus.mem_ack = 1'b1; bus.mem_rdata = 16'h4444;
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++; if ((bus.mem_read | bus.mem_write) !== 1'b0) begin bad++; $display("FAIL halt_no_cmd[%0d]: got %b%b want 00", k, bus.mem_read, bus.mem_write); end
        end
        bus.halt = 1'b0;
        tick();
        checks++; if (bus.mem_read !== 1'b1)     begin bad++; $display("FAIL halt_release_grant: got %b want 1", bus.mem_read); end
        checks++; if (bus.mem_addr !== 16'h00B0) begin bad++; $display("FAIL halt_release_d: got %h want 00b0", bus.mem_addr); end
        bus.halt = 1'b1;
        tick();
        checks++; if (bus.d_ready  !== 1'b1)     begin bad++; $display("FAIL halt_inflight_ready: got %b want 1", bus.d_ready); end
        checks++; if (bus.d_rdata  !== 16'h4444) begin bad++; $display("FAIL halt_inflight_rdata: got %h want 4444", bus.d_rdata); end
        bus.d_req = 1'b0; bus.i_req = 1'b0; bus.halt = 1'b0; bus.mem_ack = 1'b0;
        tick(); tick();
    endtask

    initial begin
        checks = 0;
        bad    = 0;
        test_reset();
        test_fetch();
        test_collision();
        test_starvation();
        test_flush();
        test_reset_mid();
        test_halt();
        $display("test done: total=%0d bad=%0d", checks, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have exactly one clock and an asynchronous, active-low reset, declared first:
- clk  in  1  sole clock; all state updates on its rising edge.
- reset_n  in  1  asynchronous active-low reset.
REQ-002 The instruction-fetch requester port SHALL be:
- i_req  in  1  fetch request; held high until i_ready.
- i_addr  in  16  fetch address; stable while i_req is high.
- i_flush  in  1  discard the pending or in-flight fetch (branch/jump redirect).
- i_ready  out  1  one-cycle completion pulse.
- i_rdata  out  16  fetched word; valid when i_ready=1.
REQ-003 The data (MEM-stage) requester port SHALL be:
- d_req  in  1  data request; held high until d_ready.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  16  data address.
- d_wdata  in  16  store data.
- d_ready  out  1  one-cycle completion pulse.
- d_rdata  out  16  load data; valid when d_ready=1.
REQ-004 The control and memory ports SHALL be:
- halt  in  1  stop issuing new grants.
- mem_read  out  1  memory read command.
- mem_write  out  1  memory write command.
- mem_addr  out  16  memory address.
- mem_wdata  out  16  memory write data.
- mem_rdata  in  16  memory read data.
- mem_ack  in  1  memory completion; variable latency, 0 or more cycles.

Function
REQ-005 The FSM SHALL have states IDLE, GNT_I, GNT_D and RESP.
REQ-006 Arbitration SHALL happen only in IDLE. At a rising edge in IDLE with halt=0:
- the selected requester's command is registered onto the mem_* outputs;
- the FSM moves to GNT_I or GNT_D.
REQ-007 Priority: d_req wins over i_req, except when both are high and starve_cnt==2, in which case i_req wins.
REQ-008 starve_cnt (2 bits):
- increments when both are requesting and D is granted;
- clears to 0 whenever I is granted;
- saturates at 2.
REQ-009 In GNT_I, mem_read SHALL be 1, mem_write 0, and mem_addr = latched i_addr.
REQ-010 In GNT_D, mem_addr and mem_wdata SHALL be the latched values, with mem_read = ~d_we and mem_write = d_we. Commands SHALL be held constant until mem_ack.
REQ-011 On the edge where mem_ack=1 in GNT_x, the FSM SHALL:
- capture mem_rdata into the corresponding rdata register (loads and fetches only; d_rdata is unchanged for stores);
- drop mem_read and mem_write to 0;
- enter RESP.
REQ-012 In RESP, exactly one of i_ready or d_ready SHALL be 1 for exactly one cycle, then the FSM returns to IDLE. No arbitration occurs in RESP, so a request still high in RESP is not re-granted.
REQ-013 Minimum latency SHALL be 2 cycles from the request being sampled to the ready pulse (ack in the first GNT cycle); sustained throughput SHALL be at most one access per 3 cycles.
REQ-014 mem_ack in IDLE or RESP SHALL be ignored.
REQ-015 i_flush handling:
- i_flush=1 in IDLE with no grant yet: blocks fetch arbitration that cycle.
- i_flush=1 at any cycle of GNT_I: the memory access still completes, but i_ready SHALL NOT pulse in the following RESP and i_rdata is not updated.
- A d transaction is unaffected by i_flush.
REQ-016 halt=1 SHALL prevent new grants from IDLE only. An in-flight transaction SHALL complete normally, including its ready pulse.
REQ-017 When a request is not granted, its requester SHALL see ready=0, which the pipeline treats as a stall.
REQ-018 All outputs SHALL be driven from registers; there are no combinational paths from inputs to outputs.

Reset
REQ-019 While reset_n=0, asynchronously:
- state = IDLE; starve_cnt = 0;
- mem_read, mem_write, i_ready, d_ready = 0;
- mem_addr, mem_wdata, i_rdata, d_rdata = 16'h0000.
REQ-020 Reset asserted mid-transaction SHALL abandon it: no ready pulse after release, and a late mem_ack is ignored.
REQ-021 The first grant SHALL be possible at the first rising edge after reset_n rises.

Verification
REQ-022 Fetch only: i_req=1, i_addr=16'h0010, ack on the 3rd GNT cycle with mem_rdata=16'hA5A5 -> mem_read=1 for 3 cycles; i_ready pulses once with i_rdata=16'hA5A5.
REQ-023 Collision: d_req (store, d_addr=16'h0040, d_wdata=16'h1234) and i_req both high, ack immediate -> store granted first with mem_write=1 and mem_wdata=16'h1234; d_ready pulses, then the fetch is granted 3 cycles after the first grant.
REQ-024 Starvation: d_req held high continuously with i_req high, ack immediate -> D granted twice, then I granted on the 3rd arbitration; starve_cnt returns to 0.
REQ-025 Flush: fetch granted, i_flush=1 for 1 cycle before ack -> the access completes, i_ready stays 0, i_rdata is unchanged, and the FSM returns to IDLE.
REQ-026 Reset mid-access: reset_n low for 1 cycle during GNT_D, then mem_ack=1 after release -> all outputs 0, no d_ready pulse, FSM in IDLE.
REQ-027 Halt: halt=1 with both requests high -> no mem_read or mem_write for 5 cycles; after halt=0, D is granted on the next edge.
